dmem_ctl: RTL and testbench

DMEM_CTL -- requirements
Module: dmem_ctl

---
 rtl/dmem_ctl_if.sv | 26 ++
 rtl/dmem_ctl.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_ctl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctl_if.sv
// Request/response bus between a requester and the dmem_ctl data memory controller.
// The controller takes the slave modport; the requester takes the master modport.
interface dmem_ctl_if #(
    parameter int ADDR_W = 7
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              ack;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req, we, size, sgn, addr, wdata,
        input  ready, ack, err, rdata
    );

    modport slave (
        input  req, we, size, sgn, addr, wdata,
        output ready, ack, err, rdata
    );
endinterface

// File: rtl/dmem_ctl.sv
// Wait-state data memory controller: byte/half/word loads and stores with alignment faults.
// Optional macro DMEM_CTL_CLEAR_EN makes reset clear every memory word.
module dmem_ctl #(
    parameter int ADDR_W = 7,
    parameter int WAIT   = 1
) (
    input logic      clk,
    input logic      rst,
    dmem_ctl_if.slave bus
);
    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_waitCnt;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sgn;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              r_err;
    logic [31:0]       r_rdata;

    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_enterResp;
    logic              w_we;
    logic [1:0]        w_size;
    logic              w_sgn;
    logic [ADDR_W+1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_idx;
    logic              w_fault;
    logic [3:0]        w_be;
    logic [31:0]       w_laneData;
    logic              w_memWe;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_loadVal;

    assign w_accept = (r_state == ST_IDLE) && bus.req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_waitCnt == 4'd0) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_waitCnt <= 4'd0;
        end else if (w_accept && (WAIT > 0)) begin
            r_waitCnt <= CNT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_waitCnt != 4'd0)) begin
            r_waitCnt <= r_waitCnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sgn   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sgn   <= bus.sgn;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
        end
    end

    // With WAIT=0 the access completes on its acceptance edge, so live inputs are used then.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_we    = bus.we;
            w_size  = bus.size;
            w_sgn   = bus.sgn;
            w_addr  = bus.addr;
            w_wdata = bus.wdata;
        end else begin
            w_we    = r_we;
            w_size  = r_size;
            w_sgn   = r_sgn;
            w_addr  = r_addr;
            w_wdata = r_wdata;
        end
    end

    assign w_enterResp = (w_next == ST_RESP);
    assign w_idx       = w_addr[ADDR_W+1:2];

    always_comb begin
        w_fault    = 1'b0;
        w_be       = 4'b0000;
        w_laneData = w_wdata;
        case (w_size)
            2'b00: begin
                w_be       = 4'b0001 << w_addr[1:0];
                w_laneData = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_fault    = w_addr[0];
                w_be       = w_addr[1] ? 4'b1100 : 4'b0011;
                w_laneData = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_fault = (w_addr[1:0] != 2'b00);
                w_be    = 4'b1111;
            end
            default: w_fault = 1'b1;
        endcase
    end

    // Gated by rst so a request seen while reset is held can never reach memory.
    assign w_memWe = w_enterResp && w_we && !w_fault && rst;

`ifdef DMEM_CTL_CLEAR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_laneData[i*8 +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_laneData[i*8 +: 8];
                end
            end
        end
    end
`endif

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = w_word[{w_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_loadVal = w_word;
        case (w_size)
            2'b00:   w_loadVal = w_sgn ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            2'b01:   w_loadVal = w_sgn ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default: w_loadVal = w_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_err   <= w_enterResp && w_fault;
            r_rdata <= (w_enterResp && !w_we && !w_fault) ? w_loadVal : 32'd0;
        end
    end

    assign bus.ready = (r_state == ST_IDLE);
    assign bus.ack   = (r_state == ST_RESP);
    assign bus.err   = r_err;
    assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_dmem_ctl.sv
// Directed bench for dmem_ctl: three instances with WAIT=0, 1 and 2 share clock and reset.
// Honours DMEM_CTL_CLEAR_EN for the expected memory contents after reset.
module tb_dmem_ctl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic        expErr;
        logic [31:0] expRd;
    } vec_t;

    dmem_ctl_if #(.ADDR_W(7)) bus0 ();
    dmem_ctl_if #(.ADDR_W(7)) bus1 ();
    dmem_ctl_if #(.ADDR_W(7)) bus2 ();

    dmem_ctl #(.ADDR_W(7), .WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_ctl #(.ADDR_W(7), .WAIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_ctl #(.ADDR_W(7), .WAIT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input int d, input logic rq, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [8:0] a, input logic [31:0] wd);
        case (d)
            0: begin bus0.req = rq; bus0.we = w; bus0.size = sz; bus0.sgn = sg; bus0.addr = a; bus0.wdata = wd; end
            1: begin bus1.req = rq; bus1.we = w; bus1.size = sz; bus1.sgn = sg; bus1.addr = a; bus1.wdata = wd; end
            default: begin bus2.req = rq; bus2.we = w; bus2.size = sz; bus2.sgn = sg; bus2.addr = a; bus2.wdata = wd; end
        endcase
    endtask

    task automatic peek(input int d, output logic rdy, output logic ak, output logic er, output logic [31:0] rd);
        case (d)
            0: begin rdy = bus0.ready; ak = bus0.ack; er = bus0.err; rd = bus0.rdata; end
            1: begin rdy = bus1.ready; ak = bus1.ack; er = bus1.err; rd = bus1.rdata; end
            default: begin rdy = bus2.ready; ak = bus2.ack; er = bus2.err; rd = bus2.rdata; end
        endcase
    endtask

    // One access: present at a negedge, scramble inputs after acceptance, wait (bounded) for ack.
    task automatic doAccess(input int d, input logic w, input logic [1:0] sz, input logic sg,
                            input logic [8:0] a, input logic [31:0] wd,
                            output logic rdyReq, output logic gotAck, output int lat,
                            output int rdyLow, output logic ackAfter, output logic e,
                            output logic [31:0] rd);
        logic pr, pa, pe;
        logic [31:0] pd;
        gotAck = 1'b0; lat = 0; rdyLow = 0; ackAfter = 1'b1; e = 1'b0; rd = 32'd0;
        @(negedge clk);
        drive(d, 1'b1, w, sz, sg, a, wd);
        peek(d, pr, pa, pe, pd);
        rdyReq = pr;
        @(negedge clk);
        drive(d, 1'b0, ~w, ~sz, ~sg, a ^ 9'h1FF, ~wd);
        for (int i = 0; i < 40 && !gotAck; i++) begin
            peek(d, pr, pa, pe, pd);
            if (pr !== 1'b1) rdyLow++;
            if (pa === 1'b1) begin
                gotAck = 1'b1; e = pe; rd = pd;
            end else begin
                lat++;
                @(negedge clk);
            end
        end
        if (gotAck) begin
            @(negedge clk);
            peek(d, pr, pa, pe, pd);
            ackAfter = pa;
        end
    endtask

    task automatic test_reset;
        logic pr, pa, pe;
        logic [31:0] pd;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'd0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            peek(d, pr, pa, pe, pd);
            total++;
            if (pr !== 1'b1 || pa !== 1'b0 || pe !== 1'b0 || pd !== 32'd0) begin
                bad++;
                $display("[TB] FAIL reset_state[%0d]: ready=%0b ack=%0b err=%0b rdata=%h, expected 1/0/0/0", d, pr, pa, pe, pd);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_wait0;
        vec_t v[2];
        logic rq, ga, aa, e;
        int lat, rl;
        logic [31:0] rd;
        v[0] = '{1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0};
        v[1] = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        1'b0, 32'hDEADBEEF};
        for (int i = 0; i < 2; i++) begin
            doAccess(0, v[i].we, v[i].size, v[i].sgn, v[i].addr, v[i].wdata, rq, ga, lat, rl, aa, e, rd);
            total++;
            if (ga !== 1'b1 || e !== v[i].expErr || rd !== v[i].expRd) begin
                bad++;
                $display("[TB] FAIL wait0_resp[%0d]: ack=%0b err=%0b rdata=%h, expected err=%0b rdata=%h", i, ga, e, rd, v[i].expErr, v[i].expRd);
            end
            total++;
            if (rq !== 1'b1 || lat != 0 || rl != 1 || aa !== 1'b0) begin
                bad++;
                $display("[TB] FAIL wait0_timing[%0d]: readyAtReq=%0b lat=%0d readyLow=%0d ackAfter=%0b, expected 1/0/1/0", i, rq, lat, rl, aa);
            end
        end
    endtask

    task automatic test_wait2_subword;
        vec_t v[8];
        logic rq, ga, aa, e;
        int lat, rl;
        logic [31:0] rd;
        v[0] = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h00000000, 1'b0, 32'h0};
        v[1] = '{1'b1, 2'b00, 1'b0, 9'h013, 32'h12345680, 1'b0, 32'h0};
        v[2] = '{1'b0, 2'b00, 1'b1, 9'h013, 32'h0, 1'b0, 32'hFFFFFF80};
        v[3] = '{1'b0, 2'b00, 1'b0, 9'h013, 32'h0, 1'b0, 32'h00000080};
        v[4] = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 1'b0, 32'h80000000};
        v[5] = '{1'b0, 2'b01, 1'b1, 9'h012, 32'h0, 1'b0, 32'hFFFF8000};
        v[6] = '{1'b0, 2'b01, 1'b0, 9'h012, 32'h0, 1'b0, 32'h00008000};
        v[7] = '{1'b0, 2'b10, 1'b1, 9'h010, 32'h0, 1'b0, 32'h80000000};
        for (int i = 0; i < 8; i++) begin
            doAccess(2, v[i].we, v[i].size, v[i].sgn, v[i].addr, v[i].wdata, rq, ga, lat, rl, aa, e, rd);
            total++;
            if (ga !== 1'b1 || e !== v[i].expErr || rd !== v[i].expRd) begin
                bad++;
                $display("[TB] FAIL wait2_resp[%0d]: ack=%0b err=%0b rdata=%h, expected err=%0b rdata=%h", i, ga, e, rd, v[i].expErr, v[i].expRd);
            end
            total++;
            if (rq !== 1'b1 || lat != 2 || rl != 3 || aa !== 1'b0) begin
                bad++;
                $display("[TB] FAIL wait2_timing[%0d]: readyAtReq=%0b lat=%0d readyLow=%0d ackAfter=%0b, expected 1/2/3/0", i, rq, lat, rl, aa);
            end
        end
    endtask

    task automatic test_faults;
        vec_t v[8];
        logic rq, ga, aa, e;
        int lat, rl;
        logic [31:0] rd;
        v[0] = '{1'b1, 2'b10, 1'b0, 9'h020, 32'h01020304, 1'b0, 32'h0};
        v[1] = '{1'b1, 2'b01, 1'b0, 9'h021, 32'h0000A5A5, 1'b1, 32'h0};
        v[2] = '{1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 1'b0, 32'h01020304};
        v[3] = '{1'b0, 2'b11, 1'b0, 9'h020, 32'h0, 1'b1, 32'h0};
        v[4] = '{1'b0, 2'b10, 1'b0, 9'h022, 32'h0, 1'b1, 32'h0};
        v[5] = '{1'b0, 2'b01, 1'b1, 9'h023, 32'h0, 1'b1, 32'h0};
        v[6] = '{1'b1, 2'b00, 1'b0, 9'h021, 32'h000000EE, 1'b0, 32'h0};
        v[7] = '{1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 1'b0, 32'h0102EE04};
        for (int i = 0; i < 8; i++) begin
            doAccess(2, v[i].we, v[i].size, v[i].sgn, v[i].addr, v[i].wdata, rq, ga, lat, rl, aa, e, rd);
            total++;
            if (ga !== 1'b1 || e !== v[i].expErr || rd !== v[i].expRd || aa !== 1'b0) begin
                bad++;
                $display("[TB] FAIL fault[%0d]: ack=%0b err=%0b rdata=%h ackAfter=%0b, expected err=%0b rdata=%h", i, ga, e, rd, aa, v[i].expErr, v[i].expRd);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic        bWe[3]    = '{1'b1, 1'b0, 1'b0};
        logic [1:0]  bSize[3]  = '{2'b10, 2'b10, 2'b00};
        logic [8:0]  bAddr[3]  = '{9'h040, 9'h040, 9'h041};
        logic [31:0] bWdata[3] = '{32'h11223344, 32'h0, 32'h0};
        logic [31:0] bExp[3]   = '{32'h0, 32'h11223344, 32'h00000033};
        logic r0, r1, a1, r2, a2, e2, pe, rq, ga, aa;
        logic [31:0] pd, rd2, rd;
        int lat, rl;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            peek(1, r0, pe, pe, pd);
            drive(1, 1'b1, bWe[i], bSize[i], 1'b0, bAddr[i], bWdata[i]);
            @(negedge clk);
            peek(1, r1, a1, pe, pd);
            drive(1, 1'b1, 1'b1, 2'b10, 1'b1, 9'h040, 32'hFFFFFFFF);
            @(negedge clk);
            peek(1, r2, a2, e2, rd2);
            total++;
            if (r0 !== 1'b1 || r1 !== 1'b0 || a1 !== 1'b0 || r2 !== 1'b0 || a2 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b_timing[%0d]: ready idle/wait/resp=%0b/%0b/%0b ack wait/resp=%0b/%0b, expected 1/0/0 0/1", i, r0, r1, r2, a1, a2);
            end
            total++;
            if (e2 !== 1'b0 || rd2 !== bExp[i]) begin
                bad++;
                $display("[TB] FAIL b2b_resp[%0d]: err=%0b rdata=%h, expected err=0 rdata=%h", i, e2, rd2, bExp[i]);
            end
        end
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'd0);
        doAccess(1, 1'b0, 2'b10, 1'b0, 9'h040, 32'd0, rq, ga, lat, rl, aa, pe, rd);
        total++;
        if (ga !== 1'b1 || rd !== 32'h11223344 || lat != 1 || rl != 2) begin
            bad++;
            $display("[TB] FAIL b2b_readback: ack=%0b rdata=%h lat=%0d readyLow=%0d, expected 1 11223344 1 2", ga, rd, lat, rl);
        end
    endtask

    task automatic test_reset_mid_access;
        logic rq, ga, aa, e, pr, pa, pe, sawAck;
        logic [31:0] rd, pd, expWord;
        int lat, rl;
        doAccess(2, 1'b1, 2'b10, 1'b0, 9'h030, 32'hCAFEF00D, rq, ga, lat, rl, aa, e, rd);
        total++;
        if (ga !== 1'b1 || e !== 1'b0 || rd !== 32'd0) begin
            bad++;
            $display("[TB] FAIL rstmid_prestore: ack=%0b err=%0b rdata=%h, expected 1/0/0", ga, e, rd);
        end
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 2'b10, 1'b0, 9'h030, 32'h0BADBEEF);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'd0);
        peek(2, pr, pa, pe, pd);
        total++;
        if (pr !== 1'b0 || pa !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_inwait: ready=%0b ack=%0b, expected 0/0", pr, pa);
        end
        rst = 1'b0;
        #1;
        peek(2, pr, pa, pe, pd);
        total++;
        if (pr !== 1'b1 || pa !== 1'b0 || pe !== 1'b0 || pd !== 32'd0) begin
            bad++;
            $display("[TB] FAIL rstmid_outputs: ready=%0b ack=%0b err=%0b rdata=%h, expected 1/0/0/0", pr, pa, pe, pd);
        end
        @(negedge clk);
        rst = 1'b1;
        sawAck = 1'b0;
        repeat (6) begin
            @(negedge clk);
            peek(2, pr, pa, pe, pd);
            if (pa !== 1'b0 || pe !== 1'b0 || pd !== 32'd0) sawAck = 1'b1;
        end
        total++;
        if (sawAck !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_noack: activity after abort=%0b, expected 0", sawAck);
        end
`ifdef DMEM_CTL_CLEAR_EN
        expWord = 32'h00000000;
`else
        expWord = 32'hCAFEF00D;
`endif
        doAccess(2, 1'b0, 2'b10, 1'b0, 9'h030, 32'd0, rq, ga, lat, rl, aa, e, rd);
        total++;
        if (ga !== 1'b1 || e !== 1'b0 || rd !== expWord) begin
            bad++;
            $display("[TB] FAIL rstmid_target: ack=%0b err=%0b rdata=%h, expected 1/0/%h", ga, e, rd, expWord);
        end
    endtask

    task automatic test_clear;
        logic [8:0]  cAddr[2] = '{9'h000, 9'h1FC};
        logic rq, ga, aa, e;
        logic [31:0] rd, expWord;
        int lat, rl;
        for (int i = 0; i < 2; i++) begin
            doAccess(0, 1'b1, 2'b10, 1'b0, cAddr[i], 32'h12345678, rq, ga, lat, rl, aa, e, rd);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
`ifdef DMEM_CTL_CLEAR_EN
        expWord = 32'h00000000;
`else
        expWord = 32'h12345678;
`endif
        for (int i = 0; i < 2; i++) begin
            doAccess(0, 1'b0, 2'b10, 1'b0, cAddr[i], 32'd0, rq, ga, lat, rl, aa, e, rd);
            total++;
            if (ga !== 1'b1 || e !== 1'b0 || rd !== expWord) begin
                bad++;
                $display("[TB] FAIL clear[%0d]: ack=%0b err=%0b rdata=%h, expected 1/0/%h", i, ga, e, rd, expWord);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_wait0();
        test_wait2_subword();
        test_faults();
        test_back_to_back();
        test_reset_mid_access();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
